ddr_store_writer: RTL

// Write-direction counterpart of the MEM-stage DDR3 read path: accepts 32-bit stores from MEM, buffers them
// in a small FIFO and drives the write side of the DDR3 IP user interface. This means cmd=write, addr,
// wr_data, wr_data_en, wr_data_end and wr_data_mask. Sits between Memory and the DDR3 IP, sharing its cmd port

---
 rtl/ddr_store_writer_pkg.sv | 27 ++
 rtl/ddr_store_writer_if.sv | 75 +++++++
 rtl/ddr_store_writer_fifo.sv | 79 +++++++
 rtl/ddr_store_writer.sv | 111 +++++++++++
 4 files changed

// File: rtl/ddr_store_writer_pkg.sv
// ddr_store_writer_pkg
// Shared types and constants for the DDR3 store write path.
//   DDR_CMD_WRITE / DDR_CMD_READ : DDR3 IP user-interface command encodings
//   store_req_t                  : one queued store (byte address, data, byte enables)
//   wr_state_t                   : write-path FSM states
package ddr_store_writer_pkg;

    localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
    localparam logic [2:0] DDR_CMD_READ  = 3'b001;

    // Width of a 32-byte line tag taken from a 32-bit byte address.
    localparam int unsigned LineTagW = 27;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_req_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StData = 2'd2,
        StDone = 2'd3
    } wr_state_t;

endpackage

// File: rtl/ddr_store_writer_if.sv
// ddr_store_writer_if
// Bundles the MEM store-request port, the write side of the DDR3 IP user interface and the
// hazard/status signals of ddr_store_writer.
//   slave  : seen by ddr_store_writer (accepts stores, drives the DDR3 IP write side)
//   master : seen by the MEM stage / DDR3 IP model (drives requests and IP ready signals)
interface ddr_store_writer_if #(
    parameter int unsigned ADDR_W     = 29,
    parameter int unsigned APP_DATA_W = 256
);

    logic                    init_calib_complete_i;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [31:0]             req_addr_i;
    logic [31:0]             req_data_i;
    logic [3:0]              req_be_i;
    logic                    ddr_cmd_rdy_i;
    logic                    ddr_cmd_en_o;
    logic [2:0]              ddr_cmd_o;
    logic [ADDR_W-1:0]       ddr_addr_o;
    logic                    ddr_write_rdy_i;
    logic                    ddr_write_en_o;
    logic                    ddr_write_end_o;
    logic [APP_DATA_W-1:0]   ddr_write_data_o;
    logic [APP_DATA_W/8-1:0] ddr_write_mask_o;
    logic [31:0]             hazard_addr_i;
    logic                    hazard_o;
    logic                    busy_o;
    logic                    done_o;

    modport slave (
        input  init_calib_complete_i,
        input  req_valid_i,
        output req_ready_o,
        input  req_addr_i,
        input  req_data_i,
        input  req_be_i,
        input  ddr_cmd_rdy_i,
        output ddr_cmd_en_o,
        output ddr_cmd_o,
        output ddr_addr_o,
        input  ddr_write_rdy_i,
        output ddr_write_en_o,
        output ddr_write_end_o,
        output ddr_write_data_o,
        output ddr_write_mask_o,
        input  hazard_addr_i,
        output hazard_o,
        output busy_o,
        output done_o
    );

    modport master (
        output init_calib_complete_i,
        output req_valid_i,
        input  req_ready_o,
        output req_addr_i,
        output req_data_i,
        output req_be_i,
        output ddr_cmd_rdy_i,
        input  ddr_cmd_en_o,
        input  ddr_cmd_o,
        input  ddr_addr_o,
        output ddr_write_rdy_i,
        input  ddr_write_en_o,
        input  ddr_write_end_o,
        input  ddr_write_data_o,
        input  ddr_write_mask_o,
        output hazard_addr_i,
        input  hazard_o,
        input  busy_o,
        input  done_o
    );

endinterface

// File: rtl/ddr_store_writer_fifo.sv
// ddr_store_writer_fifo
// Store-request FIFO. Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head entry stays in the FIFO until popped, so it also represents the in-flight store.
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : no free entries
//   empty_o      : no valid entries
//   head_o       : oldest entry
//   line_tags_o  : addr[31:5] of every slot, valid_o marks the occupied ones
module ddr_store_writer_fifo
    import ddr_store_writer_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push_i,
    input  store_req_t                        push_data_i,
    input  logic                              pop_i,
    output logic                              full_o,
    output logic                              empty_o,
    output store_req_t                        head_o,
    output logic [Depth-1:0][LineTagW-1:0]    line_tags_o,
    output logic [Depth-1:0]                  valid_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    store_req_t [Depth-1:0]  mem_q;
    logic [PW-1:0]           count;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Slot i is occupied when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [AW-1:0] offs;
        valid_o = '0;
        offs    = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            offs           = AW'(i) - rd_ptr_q[AW-1:0];
            valid_o[i]     = ({1'b0, offs} < count);
            line_tags_o[i] = mem_q[i].addr[31:5];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed through valid slots.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/ddr_store_writer.sv
// ddr_store_writer
// Accepts 32-bit stores from MEM, queues them and issues each as a single-beat BL8 write on the
// DDR3 IP user interface (command handshake first, then one 256-bit data beat). Also reports
// whether a load address hits the 32-byte line of any queued or in-flight store.
//   clk, rst_n : clock, asynchronous active-low reset (abandons any in-flight write)
//   bus        : ddr_store_writer_if.slave - store request port, DDR3 IP write side,
//                hazard_addr_i/hazard_o, busy_o, done_o
module ddr_store_writer
    import ddr_store_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 29,
    parameter int unsigned APP_DATA_W = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ddr_store_writer_if.slave    bus
);

    localparam int unsigned Lanes = APP_DATA_W / 32;
    localparam int unsigned LaneW = $clog2(Lanes);

    wr_state_t                           state_q, state_d;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                push;
    logic                                pop;
    store_req_t                          push_req;
    store_req_t                          head;
    logic [FIFO_DEPTH-1:0][LineTagW-1:0] line_tags;
    logic [FIFO_DEPTH-1:0]               tag_valid;
    logic                                active;
    logic [LaneW-1:0]                    lane;
    logic [APP_DATA_W-1:0]               wr_data;
    logic [APP_DATA_W/8-1:0]             wr_mask;
    logic                                hazard;

    assign push_req = '{addr: bus.req_addr_i, data: bus.req_data_i, be: bus.req_be_i};
    assign push     = bus.req_valid_i && !fifo_full;
    assign pop      = (state_q == StData) && bus.ddr_write_rdy_i;

    ddr_store_writer_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_req),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head),
        .line_tags_o (line_tags),
        .valid_o     (tag_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!fifo_empty && bus.init_calib_complete_i) state_d = StCmd;
            StCmd:  if (bus.ddr_cmd_rdy_i) state_d = StData;
            StData: if (bus.ddr_write_rdy_i) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Head entry is held until the data handshake, so steering from it is stable throughout
    // CMD and DATA. Outside those states the bus is driven to zero.
    assign active = (state_q == StCmd) || (state_q == StData);
    assign lane   = head.addr[2 +: LaneW];

    always_comb begin
        wr_data                = '0;
        wr_mask                = '1;
        wr_data[lane*32 +: 32] = head.data;
        wr_mask[lane*4 +: 4]   = ~head.be;
    end

    // Pending-store hazard: the in-flight store is still the FIFO head, so one compare covers both.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (tag_valid[i] && (line_tags[i] == bus.hazard_addr_i[31:5])) hazard = 1'b1;
        end
    end

    assign bus.req_ready_o      = !fifo_full;
    assign bus.ddr_cmd_en_o     = (state_q == StCmd);
    assign bus.ddr_cmd_o        = DDR_CMD_WRITE;
    assign bus.ddr_addr_o       = active ? {head.addr[ADDR_W+1:5], 3'b000} : '0;
    assign bus.ddr_write_en_o   = (state_q == StData);
    assign bus.ddr_write_end_o  = (state_q == StData);
    assign bus.ddr_write_data_o = active ? wr_data : '0;
    assign bus.ddr_write_mask_o = active ? wr_mask : '0;
    assign bus.hazard_o         = hazard;
    assign bus.busy_o           = !fifo_empty || (state_q != StIdle);
    assign bus.done_o           = (state_q == StDone);

    logic unused_bits;
    assign unused_bits = ^{bus.hazard_addr_i[4:0], head.addr[1:0], head.addr[31:ADDR_W+2]};

endmodule
